flopenr_write_arbiter: RTL
==========================

Name: flopenr_write_arbiter

Overview:
- Round-robin arbiter that shares one enable-register write port (en/d pair of a WIDTH-bit flopenr bank) among N requesters.
- Samples requests each cycle and registers exactly one winner. Drives the shared en/d for one cycle and returns a one-cycle ack to the winner.
- Sits between pipeline/control agents and the shared state register.
- Downstream back-pressure via `ready`.

Parameters:
- N, 4, number of requesters (2..8).
- WIDTH, 8, data width of the shared register.
- IDXW, $clog2(N), width of grant index.

Ports:
- clk  input  1  clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  N  per-requester write request; level, held until ack.
- data  input  N*WIDTH  packed write data; requester i at bits [i*WIDTH +: WIDTH].
- ready  input  1  downstream can accept a write this cycle.
- wen  output  1  registered enable to shared flopenr `en`.
- wdata  output  WIDTH  registered data to shared flopenr `d`.
- ack  output  N  registered one-hot grant acknowledge, one-cycle pulse.
- grant_idx  output  IDXW  index of the last winner; holds between grants.
- busy  output  1  registered; 1 when any unmasked req seen last cycle but not granted (`ready` low).

Behaviour:
- Reset (async, immediate) values:
  - wen=0, wdata=0, ack=0, grant_idx=0, busy=0.
  - Round-robin pointer ptr=0.
  - Any in-flight grant is dropped; requesters re-arbitrate after reset deasserts.
- Eligibility in cycle t:
  - elig[i] = req[i] & ~ack[i].
  - The ack mask prevents a double grant while the requester is dropping req.
- Selection (combinational, cycle t):
  - Search elig starting at ptr, ascending with wrap modulo N.
  - First set bit wins (index w).
- Registered at edge ending cycle t, if ready=1 and any elig:
  - wen=1, wdata=data[w], ack=onehot(w), grant_idx=w, ptr=(w+1) mod N, busy=0.
- Registered if ready=0:
  - wen=0, ack=0, ptr and grant_idx hold.
  - wdata holds its previous value.
  - busy=|elig.
- Registered if no elig and ready=1: wen=0, ack=0, busy=0, everything else holds.
- Latency: req sampled in cycle t; wen/ack high in cycle t+1; the flopenr captures at the end of t+1.
- Throughput:
  - One write per cycle when ≥2 requesters are continuously eligible.
  - A single requester holding req continuously is granted every other cycle because of the ack mask.
- Fairness: any continuously asserted req is granted within N grants of becoming eligible.
- Wrap-around: w=N-1 sets ptr=0.
- ready drop: no grant is lost. The selection is recomputed from the current ptr when ready returns.
- Simultaneous events: a requester deasserting req in the same cycle it would win is not granted. Selection uses the sampled value only.
- data is sampled only from the winner in its winning cycle; other lanes are don't-care.

Optional Feature:
- Macro: ARB_FIXED_PRIO_EN.
- Defined: round-robin is disabled and ptr is removed/tied to 0. The lowest eligible index always wins, so index 0 has the highest priority. The fairness guarantee is void; all other rules are unchanged.
- Undefined: round-robin as above.

Test Plan:
- Reset then idle (req=0, ready=1) for 5 cycles -> wen=0, ack=0, wdata=0, grant_idx=0, busy=0 throughout.
- Single requester: req=4'b0100, data lane2=8'h4 held 4 cycles -> wen/ack=4'b0100 in cycles t+1 and t+3 only, wdata=8'h04, grant_idx=2.
- All four req high with data lanes 8'h10,8'h20,8'h30,8'h40 and ready=1 -> wdata sequence 10,20,30,40,10…, ack rotates 0001,0010,0100,1000, wen=1 every cycle.
- ready=0 for 3 cycles with req=4'b1001, ptr=1 -> wen=0, ack=0, busy=1. After ready=1, first grant is index 3 (wdata=lane3), then index 0.
- Async reset asserted mid-cycle during a grant (wen=1) -> wen, ack, wdata clear immediately. After release with req=4'b0011, first grant is index 0.
- With ARB_FIXED_PRIO_EN defined and req=4'b1111 held while ack-masking -> grants alternate index 0, 1, 0, 1…; index 2 and 3 never granted.

Source files
------------

// File: rtl/flopenr_write_arbiter.sv
// Round-robin arbiter sharing one flopenr en/d write port among N requesters.
// Define ARB_FIXED_PRIO_EN for fixed priority (index 0 highest, no rotation).
module flopenr_write_arbiter #(
  parameter int N     = 4,
  parameter int WIDTH = 8,
  parameter int IDXW  = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         req,
  input  logic [N*WIDTH-1:0]   data,
  input  logic                 ready,
  output logic                 wen,
  output logic [WIDTH-1:0]     wdata,
  output logic [N-1:0]         ack,
  output logic [IDXW-1:0]      grant_idx,
  output logic                 busy
);

  logic [N-1:0]     elig;
  logic             any_elig;
  logic [IDXW-1:0]  win;
  logic [IDXW-1:0]  ptr;
  logic [IDXW:0]    sum;
  logic [IDXW-1:0]  idx;
  logic [WIDTH-1:0] lane [N];

  // A requester acked this cycle is still dropping req; mask it out.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_lane
      assign elig[gi] = req[gi] & ~ack[gi];
      assign lane[gi] = data[gi*WIDTH +: WIDTH];
    end
  endgenerate

  assign any_elig = |elig;

  always_comb begin
    win = '0;
    sum = '0;
    idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      sum = {1'b0, ptr} + (IDXW+1)'(k);
      if (sum >= (IDXW+1)'(N)) sum = sum - (IDXW+1)'(N);
      idx = sum[IDXW-1:0];
      // Scanning downward lets the nearest eligible index overwrite later ones.
      if (elig[idx]) win = idx;
    end
  end

`ifdef ARB_FIXED_PRIO_EN
  assign ptr = '0;
`else
  logic [IDXW-1:0] ptr_reg;
  logic [IDXW-1:0] ptr_next;

  assign ptr      = ptr_reg;
  assign ptr_next = (win == IDXW'(N - 1)) ? '0 : win + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_reg <= '0;
    end else if (ready && any_elig) begin
      ptr_reg <= ptr_next;
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wen       <= 1'b0;
      wdata     <= '0;
      ack       <= '0;
      grant_idx <= '0;
      busy      <= 1'b0;
    end else if (ready && any_elig) begin
      wen       <= 1'b1;
      wdata     <= lane[win];
      ack       <= {{(N-1){1'b0}}, 1'b1} << win;
      grant_idx <= win;
      busy      <= 1'b0;
    end else begin
      wen  <= 1'b0;
      ack  <= '0;
      busy <= ~ready & any_elig;
    end
  end

endmodule
